he_hssi_csr_arb: RTL and testbench
==================================

HE_HSSI_CSR_ARB -- requirements
Module: he_hssi_csr_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of AVMM CSR requesters (2..8).
REQ-002 SHALL have parameter AVMM_ADDR_W, default 16, CSR address width.
REQ-003 SHALL have parameter AVMM_DATA_W, default 32, CSR data width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, maximum downstream waitrequest cycles per access.
REQ-005 SHALL have port clk  input  1  single clock for all logic.
REQ-006 SHALL have port softreset  input  1  reset; synchronous, active-high.
REQ-007 SHALL have port i_req_addr  input  NUM_REQ*AVMM_ADDR_W  per-requester address, requester n at slice n.
REQ-008 SHALL have port i_req_read  input  NUM_REQ  per-requester read strobe.
REQ-009 SHALL have port i_req_write  input  NUM_REQ  per-requester write strobe.
REQ-010 SHALL have port i_req_writedata  input  NUM_REQ*AVMM_DATA_W  per-requester write data.
REQ-011 SHALL have port i_req_port_sel  input  NUM_REQ*4  per-requester Ethernet channel select.
REQ-012 SHALL have port o_req_readdata  output  AVMM_DATA_W  shared read data, valid for the responding requester.
REQ-013 SHALL have port o_req_waitrequest  output  NUM_REQ  per-requester waitrequest.
REQ-014 SHALL have ports o_avmm_addr/o_avmm_read/o_avmm_write/o_avmm_writedata  output  AVMM_ADDR_W/1/1/AVMM_DATA_W  downstream command to traffic-controller CSR space.
REQ-015 SHALL have ports i_avmm_readdata  input  AVMM_DATA_W, i_avmm_waitrequest  input  1  downstream response.
REQ-016 SHALL have port o_csr_port_sel  output  4  channel select of the active access.
REQ-017 SHALL have port o_timeout_err  output  1  one-cycle pulse on an aborted access.
REQ-018 SHALL have port o_grant_id  output  $clog2(NUM_REQ)  index of the current/last granted requester.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, RESP.
REQ-020 IDLE: when any requester has read|write, SHALL select one round-robin starting at (last_grant+1) mod NUM_REQ, register its addr/writedata/port_sel/op, and go to ISSUE.
REQ-021 ISSUE: SHALL drive registered command with o_avmm_read or o_avmm_write high, stable until i_avmm_waitrequest is sampled low, then capture i_avmm_readdata and go to RESP.
REQ-022 RESP: SHALL drive o_req_waitrequest[grant]=0 for exactly one cycle with o_req_readdata = captured data (reads) or 0 (writes), then go to IDLE.
REQ-023 o_req_waitrequest SHALL be 1 for every requester except the granted one in RESP.
REQ-024 Latency: request sampled in IDLE at cycle 0 -> downstream strobe in cycle 1 -> with zero downstream wait, requester waitrequest low in cycle 2; back-to-back grants every 3 cycles minimum.
REQ-025 Read and write both high from one requester SHALL be executed as a write only.
REQ-026 Requester deasserting its strobe after grant SHALL NOT cancel the access; it completes downstream and RESP still occurs.
REQ-027 Wait counter SHALL clear on entering ISSUE; if it reaches TIMEOUT_CYCLES-1 with i_avmm_waitrequest still 1, SHALL drop downstream strobe, set captured data to all ones, pulse o_timeout_err, go to RESP.
REQ-028 last_grant SHALL update on entry to ISSUE; wrap-around from NUM_REQ-1 to 0.
REQ-029 o_grant_id SHALL equal last_grant; o_csr_port_sel SHALL hold the registered port_sel.
REQ-030 Downstream strobes SHALL be 0 outside ISSUE; never both 1.

Reset
REQ-031 With softreset high at a clk edge, next cycle SHALL give: state IDLE, o_avmm_read/write 0, o_avmm_addr/writedata 0, o_csr_port_sel 0, o_req_readdata 0, o_req_waitrequest all ones, o_timeout_err 0, last_grant NUM_REQ-1 (requester 0 highest priority), counter 0.
REQ-032 Reset mid-ISSUE SHALL abort the access without RESP and without o_timeout_err.

Verification
REQ-033 Req0 read addr 0x0010, downstream waitrequest 0 -> o_avmm_read cycle 1, o_req_waitrequest[0]=0 cycle 2 with readdata = i_avmm_readdata (e.g. 0xA5A5_0001).
REQ-034 Req0 and req1 write continuously from reset -> grant order 0,1,0,1; each sees exactly one waitrequest-low cycle per access.
REQ-035 Req1 read+write simultaneously, writedata 0x1234 -> only o_avmm_write asserts, data 0x1234.
REQ-036 Downstream waitrequest stuck 1, TIMEOUT_CYCLES=16 -> strobe drops after 16 ISSUE cycles, o_timeout_err one pulse, readdata 0xFFFF_FFFF to requester.
REQ-037 softreset asserted 3 cycles into a stalled ISSUE -> strobes 0 next cycle, no RESP, next request after reset granted to requester 0.
REQ-038 Requester drops read one cycle after grant, port_sel 3 -> access completes, o_csr_port_sel=3 throughout ISSUE, RESP pulse still issued.

Source files
------------

// File: rtl/he_hssi_csr_arb.sv
// Round-robin arbiter that funnels several AVMM CSR requesters onto one
// downstream traffic-controller CSR port, with a bounded wait per access.
module he_hssi_csr_arb #(
  parameter int NUM_REQ        = 2,
  parameter int AVMM_ADDR_W    = 16,
  parameter int AVMM_DATA_W    = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           softreset,
  input  logic [NUM_REQ*AVMM_ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ-1:0]             i_req_read,
  input  logic [NUM_REQ-1:0]             i_req_write,
  input  logic [NUM_REQ*AVMM_DATA_W-1:0] i_req_writedata,
  input  logic [NUM_REQ*4-1:0]           i_req_port_sel,
  output logic [AVMM_DATA_W-1:0]         o_req_readdata,
  output logic [NUM_REQ-1:0]             o_req_waitrequest,
  output logic [AVMM_ADDR_W-1:0]         o_avmm_addr,
  output logic                           o_avmm_read,
  output logic                           o_avmm_write,
  output logic [AVMM_DATA_W-1:0]         o_avmm_writedata,
  input  logic [AVMM_DATA_W-1:0]         i_avmm_readdata,
  input  logic                           i_avmm_waitrequest,
  output logic [3:0]                     o_csr_port_sel,
  output logic                           o_timeout_err,
  output logic [$clog2(NUM_REQ)-1:0]     o_grant_id
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  logic [1:0]             state;
  logic [GW-1:0]          last_grant;
  logic [AVMM_ADDR_W-1:0] cmd_addr;
  logic [AVMM_DATA_W-1:0] cmd_wdata;
  logic [3:0]             cmd_port_sel;
  logic                   op_read;
  logic                   op_write;
  logic [CW-1:0]          wait_cnt;
  logic [AVMM_DATA_W-1:0] resp_data;
  logic                   timeout_err;

  logic                   any_req;
  logic [GW-1:0]          pick;
  logic [GW-1:0]          cand;

  // Search starts one past the last winner, so the most recent grantee has
  // the lowest priority on the next round.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    any_req = 1'b0;
    pick    = last_grant;
    cand    = last_grant;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = GW'((int'(last_grant) + i) % NUM_REQ);
      if (!any_req && (i_req_read[cand] || i_req_write[cand])) begin
        any_req = 1'b1;
        pick    = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (softreset) begin
      state        <= ST_IDLE;
      last_grant   <= GW'(NUM_REQ - 1);
      cmd_addr     <= '0;
      cmd_wdata    <= '0;
      cmd_port_sel <= '0;
      op_read      <= 1'b0;
      op_write     <= 1'b0;
      wait_cnt     <= '0;
      resp_data    <= '0;
      timeout_err  <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            state        <= ST_ISSUE;
            last_grant   <= pick;
            cmd_addr     <= i_req_addr[pick*AVMM_ADDR_W +: AVMM_ADDR_W];
            cmd_wdata    <= i_req_writedata[pick*AVMM_DATA_W +: AVMM_DATA_W];
            cmd_port_sel <= i_req_port_sel[pick*4 +: 4];
            // A simultaneous read and write collapses to a write.
            op_write     <= i_req_write[pick];
            op_read      <= i_req_read[pick] & ~i_req_write[pick];
            wait_cnt     <= '0;
          end
        end
        ST_ISSUE: begin
          if (!i_avmm_waitrequest) begin
            resp_data <= op_read ? i_avmm_readdata : '0;
            state     <= ST_RESP;
          end else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            resp_data   <= '1;
            timeout_err <= 1'b1;
            state       <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Strobes are gated by state, so they vanish the cycle an access ends or
  // a reset hits, and op_read/op_write are never both set.
  assign o_avmm_read      = (state == ST_ISSUE) && op_read;
  assign o_avmm_write     = (state == ST_ISSUE) && op_write;
  assign o_avmm_addr      = cmd_addr;
  assign o_avmm_writedata = cmd_wdata;
  assign o_csr_port_sel   = cmd_port_sel;
  assign o_timeout_err    = timeout_err;
  assign o_grant_id       = last_grant;
  assign o_req_readdata   = (state == ST_RESP) ? resp_data : '0;

  always_comb begin
    o_req_waitrequest = '1;
    if (state == ST_RESP) o_req_waitrequest[last_grant] = 1'b0;
  end

endmodule

// File: tb/tb_he_hssi_csr_arb.sv
// Directed bench for he_hssi_csr_arb: read/write paths, round-robin order,
// read+write collapse, timeout abort, reset mid-access, strobe drop after grant.
module tb_he_hssi_csr_arb;

  localparam int NUM_REQ = 2;
  localparam int AW      = 16;
  localparam int DW      = 32;
  localparam int TO      = 16;

  logic                 clk = 1'b0;
  logic                 softreset;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ-1:0]    req_read;
  logic [NUM_REQ-1:0]    req_write;
  logic [NUM_REQ*DW-1:0] req_wdata;
  logic [NUM_REQ*4-1:0]  req_port_sel;
  logic [DW-1:0]         req_readdata;
  logic [NUM_REQ-1:0]    req_waitrequest;
  logic [AW-1:0]         avmm_addr;
  logic                  avmm_read;
  logic                  avmm_write;
  logic [DW-1:0]         avmm_writedata;
  logic [DW-1:0]         avmm_readdata;
  logic                  avmm_waitrequest;
  logic [3:0]            csr_port_sel;
  logic                  timeout_err;
  logic [0:0]            grant_id;

  int checks = 0;
  int errors = 0;

  he_hssi_csr_arb #(
    .NUM_REQ(NUM_REQ), .AVMM_ADDR_W(AW), .AVMM_DATA_W(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk                (clk),
    .softreset          (softreset),
    .i_req_addr         (req_addr),
    .i_req_read         (req_read),
    .i_req_write        (req_write),
    .i_req_writedata    (req_wdata),
    .i_req_port_sel     (req_port_sel),
    .o_req_readdata     (req_readdata),
    .o_req_waitrequest  (req_waitrequest),
    .o_avmm_addr        (avmm_addr),
    .o_avmm_read        (avmm_read),
    .o_avmm_write       (avmm_write),
    .o_avmm_writedata   (avmm_writedata),
    .i_avmm_readdata    (avmm_readdata),
    .i_avmm_waitrequest (avmm_waitrequest),
    .o_csr_port_sel     (csr_port_sel),
    .o_timeout_err      (timeout_err),
    .o_grant_id         (grant_id)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    softreset        = 1'b1;
    req_addr         = '0;
    req_read         = '0;
    req_write        = '0;
    req_wdata        = '0;
    req_port_sel     = '0;
    avmm_readdata    = '0;
    avmm_waitrequest = 1'b0;
    step();
    step();
    check("rst_read",      64'(avmm_read), 64'h0);
    check("rst_write",     64'(avmm_write), 64'h0);
    check("rst_addr",      64'(avmm_addr), 64'h0);
    check("rst_wdata",     64'(avmm_writedata), 64'h0);
    check("rst_port_sel",  64'(csr_port_sel), 64'h0);
    check("rst_readdata",  64'(req_readdata), 64'h0);
    check("rst_waitreq",   64'(req_waitrequest), 64'h3);
    check("rst_timeout",   64'(timeout_err), 64'h0);
    check("rst_grant_id",  64'(grant_id), 64'h1);
    softreset = 1'b0;
    step();

    // Single read from requester 0, zero downstream wait.
    req_addr[15:0] = 16'h0010;
    req_read       = 2'b01;
    avmm_readdata  = 32'hA5A5_0001;
    step();
    check("rd_issue_read",  64'(avmm_read), 64'h1);
    check("rd_issue_write", 64'(avmm_write), 64'h0);
    check("rd_issue_addr",  64'(avmm_addr), 64'h0010);
    check("rd_issue_grant", 64'(grant_id), 64'h0);
    check("rd_issue_wreq",  64'(req_waitrequest), 64'h3);
    step();
    check("rd_resp_wreq",   64'(req_waitrequest), 64'h2);
    check("rd_resp_data",   64'(req_readdata), 64'hA5A5_0001);
    check("rd_resp_strobe", 64'(avmm_read), 64'h0);
    req_read = 2'b00;
    step();
    check("rd_idle_wreq",   64'(req_waitrequest), 64'h3);

    // Both requesters write continuously from reset: grants alternate 0,1,0,1.
    softreset = 1'b1;
    step();
    softreset = 1'b0;
    req_addr  = {16'h0200, 16'h0100};
    req_wdata = {32'h1111_0001, 32'h0000_0000};
    req_write = 2'b11;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("rr%0d_grant", k), 64'(grant_id), 64'(k % 2));
      check($sformatf("rr%0d_write", k), 64'(avmm_write), 64'h1);
      check($sformatf("rr%0d_addr", k),  64'(avmm_addr), (k % 2) ? 64'h0200 : 64'h0100);
      step();
      check($sformatf("rr%0d_resp_wreq", k), 64'(req_waitrequest), (k % 2) ? 64'h1 : 64'h2);
      check($sformatf("rr%0d_resp_data", k), 64'(req_readdata), 64'h0);
      step();
      check($sformatf("rr%0d_idle_wreq", k), 64'(req_waitrequest), 64'h3);
    end
    req_write = 2'b00;

    // Requester 1 asserts read and write together: executed as a write only.
    req_wdata[63:32] = 32'h0000_1234;
    req_read         = 2'b10;
    req_write        = 2'b10;
    step();
    check("rw_write", 64'(avmm_write), 64'h1);
    check("rw_read",  64'(avmm_read), 64'h0);
    check("rw_wdata", 64'(avmm_writedata), 64'h1234);
    check("rw_grant", 64'(grant_id), 64'h1);
    req_read  = 2'b00;
    req_write = 2'b00;
    step();
    check("rw_resp_wreq", 64'(req_waitrequest), 64'h1);
    step();

    // Downstream stuck in waitrequest: abort after 16 ISSUE cycles.
    avmm_waitrequest = 1'b1;
    req_read         = 2'b01;
    for (int k = 0; k < 16; k++) step();
    check("to_last_issue_read", 64'(avmm_read), 64'h1);
    check("to_last_issue_err",  64'(timeout_err), 64'h0);
    step();
    check("to_strobe_drop", 64'(avmm_read), 64'h0);
    check("to_err_pulse",   64'(timeout_err), 64'h1);
    check("to_resp_wreq",   64'(req_waitrequest), 64'h2);
    check("to_resp_data",   64'(req_readdata), 64'hFFFF_FFFF);
    req_read = 2'b00;
    step();
    check("to_err_clear",   64'(timeout_err), 64'h0);
    check("to_idle_wreq",   64'(req_waitrequest), 64'h3);

    // Reset three cycles into a stalled access from requester 0.
    req_read = 2'b01;
    step();
    step();
    step();
    check("rs_stalled_read", 64'(avmm_read), 64'h1);
    req_read  = 2'b00;
    softreset = 1'b1;
    step();
    check("rs_read",    64'(avmm_read), 64'h0);
    check("rs_wreq",    64'(req_waitrequest), 64'h3);
    check("rs_timeout", 64'(timeout_err), 64'h0);
    softreset = 1'b0;
    step();
    check("rs_no_resp", 64'(req_waitrequest), 64'h3);
    avmm_waitrequest = 1'b0;
    req_read         = 2'b11;
    step();
    check("rs_next_grant", 64'(grant_id), 64'h0);
    req_read = 2'b00;
    step();
    check("rs_next_resp", 64'(req_waitrequest), 64'h2);
    step();

    // Requester 1 drops its read right after grant; access still completes.
    avmm_waitrequest    = 1'b1;
    avmm_readdata       = 32'hCAFE_0038;
    req_port_sel[7:4]   = 4'd3;
    req_read            = 2'b10;
    step();
    check("dr_grant",    64'(grant_id), 64'h1);
    check("dr_port_sel", 64'(csr_port_sel), 64'h3);
    req_read          = 2'b00;
    req_port_sel[7:4] = 4'd0;
    step();
    check("dr_hold_read",     64'(avmm_read), 64'h1);
    check("dr_hold_port_sel", 64'(csr_port_sel), 64'h3);
    avmm_waitrequest = 1'b0;
    step();
    check("dr_resp_wreq",     64'(req_waitrequest), 64'h1);
    check("dr_resp_data",     64'(req_readdata), 64'hCAFE_0038);
    check("dr_resp_port_sel", 64'(csr_port_sel), 64'h3);
    step();
    check("dr_idle_wreq",     64'(req_waitrequest), 64'h3);
    check("dr_idle_read",     64'(avmm_read), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
